// File: rtl/adc_dout_capture_pkg.sv
// adc_dout_capture_pkg: shared ADC link constants, FSM states and sample-window helper
package adc_dout_capture_pkg;
  localparam int NBITS = 12;
  localparam int CNT_MOD = 80;
  localparam int CW = $clog2(CNT_MOD);
  localparam int X_FIRST = 19;
  localparam int Y_FIRST = 51;
  typedef enum logic [1:0] {SYNC, X_SHIFT, Y_SHIFT} state_t;
  // true on the NBITS DCLK-high counts starting at first (first, first+2, ...)
  function automatic logic in_window(input logic [CW-1:0] cnt, input int first);
    int off;
    off = int'(cnt) - first;
    return off >= 0 && off <= 2 * (NBITS - 1) && off[0] == 1'b0;
  endfunction
endpackage

// File: rtl/adc_dout_capture_shift_in.sv
// adc_shift_in: MSB-first serial-in/parallel-out register with sample enable and sync clear
module adc_shift_in
  import adc_dout_capture_pkg::*;
#(
  parameter int W = NBITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] data_q
);
  logic [W-1:0] data_d;
  always_comb data_d = clr ? '0 : en ? {data_q[W-2:0], din} : data_q;
  always_ff @(posedge clk) data_q <= rst ? '0 : data_d;
endmodule

// File: rtl/adc_dout_capture.sv
// adc_dout_capture: deserialises X/Y ADC results per frame and hands them off with valid/ack
module adc_dout_capture
  import adc_dout_capture_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             Enable,
  input  logic [CW-1:0]    Cuenta,
  input  logic             ADC_DOUT,
  input  logic             PENIRQ_n,
  input  logic             Coord_Ack,
  output logic [NBITS-1:0] X_Coord,
  output logic [NBITS-1:0] Y_Coord,
  output logic             Coord_Vld,
  output logic             Overrun
);
  localparam logic [CW-1:0] X_LAST = CW'(X_FIRST + 2 * (NBITS - 1));
  localparam logic [CW-1:0] Y_LAST = CW'(Y_FIRST + 2 * (NBITS - 1));
  state_t state_q, state_d;
  logic pen_ok_q, pen_ok_d, vld_q, vld_d, ovr_q, ovr_d;
  logic frame_clr, x_en, y_en, commit;
  logic [NBITS-1:0] x_data, y_data, y_final;
  logic [NBITS-1:0] x_coord_q, x_coord_d, y_coord_q, y_coord_d;
  adc_shift_in #(.W(NBITS)) u_x (
    .clk(CLK), .rst(RST), .clr(frame_clr), .en(x_en), .din(ADC_DOUT), .data_q(x_data)
  );
  adc_shift_in #(.W(NBITS)) u_y (
    .clk(CLK), .rst(RST), .clr(frame_clr), .en(y_en), .din(ADC_DOUT), .data_q(y_data)
  );
  always_comb begin
    x_en = Enable && state_q == X_SHIFT && in_window(Cuenta, X_FIRST);
    y_en = Enable && state_q == Y_SHIFT && in_window(Cuenta, Y_FIRST);
    frame_clr = Enable && Cuenta == '0;
    state_d = state_q;
    pen_ok_d = pen_ok_q;
    commit = 1'b0;
    if (!Enable) state_d = SYNC;
    else if (frame_clr) begin
      state_d = X_SHIFT;
      pen_ok_d = 1'b1;
    end else begin
      if ((x_en || y_en) && PENIRQ_n) pen_ok_d = 1'b0;
      if (state_q == X_SHIFT && Cuenta == X_LAST) state_d = Y_SHIFT;
      if (state_q == Y_SHIFT && Cuenta == Y_LAST) begin
        state_d = SYNC;
        commit = pen_ok_d;
      end
    end
    // the Y LSB is still on ADC_DOUT during the commit cycle
    y_final = {y_data[NBITS-2:0], ADC_DOUT};
    x_coord_d = commit ? x_data : x_coord_q;
    y_coord_d = commit ? y_final : y_coord_q;
    vld_d = commit || (vld_q && !Coord_Ack);
    ovr_d = commit && vld_q && !Coord_Ack;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= SYNC;
      pen_ok_q <= 1'b0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
      x_coord_q <= '0;
      y_coord_q <= '0;
    end else begin
      state_q <= state_d;
      pen_ok_q <= pen_ok_d;
      vld_q <= vld_d;
      ovr_q <= ovr_d;
      x_coord_q <= x_coord_d;
      y_coord_q <= y_coord_d;
    end
  end
  assign X_Coord = x_coord_q;
  assign Y_Coord = y_coord_q;
  assign Coord_Vld = vld_q;
  assign Overrun = ovr_q;
endmodule

// File: tb/tb_adc_dout_capture.sv
// tb_adc_dout_capture: directed and random frames checked against a frame-level model
module tb_adc_dout_capture;
  logic CLK, RST, Enable, ADC_DOUT, PENIRQ_n, Coord_Ack;
  logic [6:0] Cuenta;
  logic [11:0] X_Coord, Y_Coord;
  logic Coord_Vld, Overrun;
  int total = 0;
  int bad = 0;
  logic m_vld = 1'b0;
  logic m_ovr = 1'b0;
  logic [11:0] m_x = '0;
  logic [11:0] m_y = '0;
  adc_dout_capture dut (
    .CLK(CLK), .RST(RST), .Enable(Enable), .Cuenta(Cuenta), .ADC_DOUT(ADC_DOUT),
    .PENIRQ_n(PENIRQ_n), .Coord_Ack(Coord_Ack), .X_Coord(X_Coord), .Y_Coord(Y_Coord),
    .Coord_Vld(Coord_Vld), .Overrun(Overrun)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at %0t: got %h want %h", tag, $time, obs, exp);
    end
  endtask
  task automatic check_all(input int c);
    chk($sformatf("vld c=%0d", c), {11'b0, Coord_Vld}, {11'b0, m_vld});
    chk($sformatf("ovr c=%0d", c), {11'b0, Overrun}, {11'b0, m_ovr});
    chk($sformatf("x c=%0d", c), X_Coord, m_x);
    chk($sformatf("y c=%0d", c), Y_Coord, m_y);
  endtask
  // one frame of Cuenta 0..ncyc-1; a frame commits only if it reaches 73 with
  // Enable high throughout, no reset, and pen down on every sample point
  task automatic run_frame(input logic [11:0] x, input logic [11:0] y, input int pen_hi_at,
                           input int en_at, input int en_len, input int ack_at,
                           input int ack_len, input int rst_at, input int ncyc);
    bit ok, xs, ys, commit;
    ok = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      xs = c >= 19 && c <= 41 && c % 2 == 1;
      ys = c >= 51 && c <= 73 && c % 2 == 1;
      Cuenta = 7'(c);
      Enable = !(c >= en_at && c < en_at + en_len);
      ADC_DOUT = xs ? x[11 - (c - 19) / 2] : ys ? y[11 - (c - 51) / 2] : 1'($urandom);
      PENIRQ_n = (c == pen_hi_at) ? 1'b1 : (xs || ys) ? 1'b0 : 1'($urandom);
      Coord_Ack = c >= ack_at && c < ack_at + ack_len;
      RST = c == rst_at;
      if (!Enable || RST || ((xs || ys) && PENIRQ_n)) ok = 1'b0;
      commit = ok && c == 73;
      @(posedge CLK);
      if (RST) begin
        m_vld = 1'b0;
        m_ovr = 1'b0;
        m_x = '0;
        m_y = '0;
      end else begin
        m_ovr = commit && m_vld && !Coord_Ack;
        if (commit) begin
          m_vld = 1'b1;
          m_x = x;
          m_y = y;
        end else if (Coord_Ack) m_vld = 1'b0;
      end
      @(negedge CLK);
      check_all(c);
    end
    RST = 1'b0;
  endtask
  initial begin
    RST = 1'b1;
    Enable = 1'b0;
    Cuenta = 7'd5;
    ADC_DOUT = 1'b0;
    PENIRQ_n = 1'b1;
    Coord_Ack = 1'b0;
    repeat (2) @(negedge CLK);
    check_all(-1);
    RST = 1'b0;
    run_frame(12'hABC, 12'h123, -1, -1, 0, -1, 0, -1, 80);
    run_frame(12'h555, 12'hAAA, 61, -1, 0, 5, 1, -1, 80);
    run_frame(12'h111, 12'h222, -1, -1, 0, -1, 0, -1, 80);
    run_frame(12'h333, 12'h444, -1, -1, 0, -1, 0, -1, 80);
    run_frame(12'h0F0, 12'h90F, -1, -1, 0, 73, 2, -1, 80);
    run_frame(12'h777, 12'h888, -1, 30, 3, -1, 0, -1, 80);
    run_frame(12'hFFF, 12'h000, -1, -1, 0, -1, 0, -1, 80);
    run_frame(12'h5A5, 12'hA5A, -1, -1, 0, -1, 0, -1, 80);
    run_frame(12'h5A5, 12'hA5A, -1, -1, 0, -1, 0, 45, 80);
    run_frame(12'h7E1, 12'h18F, -1, -1, 0, 76, 1, -1, 80);
    run_frame(12'h246, 12'h8AC, -1, -1, 0, -1, 0, -1, 30);
    run_frame(12'hC3D, 12'h4E2, -1, -1, 0, -1, 0, -1, 80);
    for (int i = 0; i < 24; i++) begin
      int pen, en_at, en_len, ack_at, ack_len, ncyc;
      pen = -1;
      en_at = -1;
      en_len = 0;
      ack_at = int'($urandom_range(0, 79));
      ack_len = int'($urandom_range(0, 3));
      ncyc = 80;
      if ($urandom_range(0, 3) == 0) pen = int'($urandom_range(0, 79));
      if ($urandom_range(0, 4) == 0) begin
        en_at = int'($urandom_range(0, 79));
        en_len = int'($urandom_range(1, 5));
      end
      if ($urandom_range(0, 7) == 0) ncyc = int'($urandom_range(10, 79));
      run_frame(12'($urandom), 12'($urandom), pen, en_at, en_len, ack_at, ack_len, -1, ncyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
